// File: rtl/huffman_bitpacker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_bitpacker_if                                                 |
// | Code-beat input, flush handshake and byte output of the bit packer.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface huffman_bitpacker_if #(
  parameter int MAX_CODE_BITS = 27
);
  localparam int LEN_W = $clog2(MAX_CODE_BITS + 1);

  logic                     code_in_valid;
  logic [MAX_CODE_BITS-1:0] code_in;
  logic [LEN_W-1:0]         code_len;
  logic                     code_ready;
  logic                     flush;
  logic                     flush_done;
  logic                     data_out_valid;
  logic [7:0]               data_out;
  logic                     overflow;

  modport master (
    output code_in_valid, code_in, code_len, flush,
    input  code_ready, flush_done, data_out_valid, data_out, overflow
  );

  modport slave (
    input  code_in_valid, code_in, code_len, flush,
    output code_ready, flush_done, data_out_valid, data_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/huffman_bitpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_bitpacker                                                    |
// | Packs variable-length code fields MSB-first into bytes; flush pads   |
// | the last partial byte with 1s and pulses flush_done.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module huffman_bitpacker #(
  parameter int MAX_CODE_BITS = 27,
  parameter int ACC_BITS      = 48
) (
  input wire             clock,
  input wire             nreset,
  huffman_bitpacker_if.slave bus
);
  localparam int CNT_W = $clog2(ACC_BITS + 1);
  localparam int PAD_W = ACC_BITS - MAX_CODE_BITS;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_PAD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state, state_next;
  logic [ACC_BITS-1:0]      acc, acc_next, acc_shifted, field_aligned;
  logic [CNT_W-1:0]         bit_count, bit_count_next, count_after, lead_zeros;
  logic [MAX_CODE_BITS-1:0] code_mask;
  logic [7:0]               data_out_r, data_out_next;
  logic                     data_valid_r, data_valid_next;
  logic                     flush_done_r, flush_done_next;
  logic                     overflow_r;
  logic                     ready, accept, emit;

  assign ready  = (state == S_RUN) && (bit_count <= CNT_W'(PAD_W));
  assign accept = bus.code_in_valid && ready;
  assign emit   = (bit_count >= CNT_W'(8));

  assign acc_shifted = emit ? (acc << 8) : acc;
  assign count_after = emit ? (bit_count - CNT_W'(8)) : bit_count;

  // Left-justify the masked field in the accumulator, then slide it behind the retained bits.
  assign code_mask     = ~({MAX_CODE_BITS{1'b1}} << bus.code_len);
  assign lead_zeros    = CNT_W'(MAX_CODE_BITS) - CNT_W'(bus.code_len);
  assign field_aligned = ({bus.code_in & code_mask, {PAD_W{1'b0}}} << lead_zeros) >> count_after;

  always_comb begin
    state_next      = state;
    acc_next        = acc;
    bit_count_next  = bit_count;
    data_out_next   = data_out_r;
    data_valid_next = 1'b0;
    flush_done_next = 1'b0;
    case (state)
      S_RUN: begin
        if (emit) begin
          data_out_next   = acc[ACC_BITS-1 -: 8];
          data_valid_next = 1'b1;
        end
        acc_next       = acc_shifted | (accept ? field_aligned : '0);
        bit_count_next = count_after + (accept ? CNT_W'(bus.code_len) : '0);
        if (bus.flush) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (emit) begin
          data_out_next   = acc[ACC_BITS-1 -: 8];
          data_valid_next = 1'b1;
          acc_next        = acc_shifted;
          bit_count_next  = count_after;
        end else if (bit_count != '0) begin
          state_next = S_PAD;
        end else begin
          state_next = S_DONE;
        end
      end
      S_PAD: begin
        data_out_next   = acc[ACC_BITS-1 -: 8] | (8'hFF >> bit_count);
        data_valid_next = 1'b1;
        acc_next        = '0;
        bit_count_next  = '0;
        state_next      = S_DONE;
      end
      S_DONE: begin
        flush_done_next = 1'b1;
        state_next      = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= S_RUN;
      acc          <= '0;
      bit_count    <= '0;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      bit_count    <= bit_count_next;
      data_out_r   <= data_out_next;
      data_valid_r <= data_valid_next;
      flush_done_r <= flush_done_next;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      overflow_r <= 1'b0;
    end else if (bus.code_in_valid && !ready) begin
      overflow_r <= 1'b1;
    end
  end

  assign bus.code_ready     = ready;
  assign bus.data_out       = data_out_r;
  assign bus.data_out_valid = data_valid_r;
  assign bus.flush_done     = flush_done_r;
  assign bus.overflow       = overflow_r;
endmodule
`default_nettype wire
